// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone bus-grant arbiter: registered one-hot grant, owner ID, held for the whole CYC.
// Optional per-grant beat limit compiled in with `define GNT_BURST_LIMIT_EN.
module wb_rr_arbiter #(
  parameter int unsigned NCH       = 5,
  parameter int unsigned IDW       = 3,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [NCH-1:0] wbs_cyc_i,
  input  logic           wb_ack_i,
  output logic [NCH-1:0] gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last, last_nxt;
  logic [NCH-1:0] gnt_nxt, win_oh;
  logic [IDW-1:0] id_nxt, win_id, hi_id, lo_id;
  logic           vld_nxt, hi_found;
  logic           any_req, owner_cyc, drop;

  assign any_req   = |wbs_cyc_i;
  assign owner_cyc = |(wbs_cyc_i & gnt);

  // Requesters above `last` outrank those at or below it; the descending scan
  // leaves the lowest index of each group, giving a wrap-around search from last+1.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (wbs_cyc_i[i-1]) begin
        if (IDW'(i-1) > last) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i-1);
        end else begin
          lo_id = IDW'(i-1);
        end
      end
    end
    win_id = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    win_oh = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      win_oh[i] = (IDW'(i) == win_id);
    end
  end

`ifdef GNT_BURST_LIMIT_EN
  logic [7:0] beat_cnt, beat_nxt, beat_inc;
  logic       others_req, limit_hit;

  assign others_req = |(wbs_cyc_i & ~gnt);
  assign beat_inc   = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
  assign limit_hit  = gnt_vld && wb_ack_i && (beat_inc == 8'(MAX_BEATS));
  assign drop       = !owner_cyc || (limit_hit && others_req);

  // A limit hit with nobody waiting keeps the grant and restarts the count.
  always_comb begin
    beat_nxt = beat_cnt;
    if (gnt_vld) begin
      if (drop || limit_hit) begin
        beat_nxt = '0;
      end else if (wb_ack_i) begin
        beat_nxt = beat_inc;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      beat_cnt <= '0;
    end else begin
      beat_cnt <= beat_nxt;
    end
  end
`else
  logic [8:0] ack_unused;

  assign ack_unused = {wb_ack_i, 8'(MAX_BEATS)};
  assign drop       = !owner_cyc;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    vld_nxt   = gnt_vld;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = BUSY;
          gnt_nxt   = win_oh;
          id_nxt    = win_id;
          vld_nxt   = 1'b1;
          last_nxt  = win_id;
        end
      end
      BUSY: begin
        if (drop) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          vld_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
      last    <= IDW'(NCH - 1);
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= id_nxt;
      gnt_vld <= vld_nxt;
      last    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter (NCH=5, MAX_BEATS=4); expectations follow GNT_BURST_LIMIT_EN.
module tb_wb_rr_arbiter;

  localparam int unsigned NCH = 5;
  localparam int unsigned IDW = 3;
`ifdef GNT_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  // Row = {wbs_cyc_i, wb_ack_i, expected gnt after the edge}
  localparam logic [10:0] PRIO_TBL [8] = '{
    {5'b00100, 1'b0, 5'b00100},
    {5'b10110, 1'b0, 5'b00100},
    {5'b10010, 1'b0, 5'b00000},
    {5'b10010, 1'b0, 5'b10000},
    {5'b10010, 1'b0, 5'b10000},
    {5'b00010, 1'b0, 5'b00000},
    {5'b00010, 1'b0, 5'b00010},
    {5'b00000, 1'b0, 5'b00000}
  };

  localparam logic [10:0] REREQ_TBL [8] = '{
    {5'b01000, 1'b0, 5'b01000},
    {5'b01001, 1'b0, 5'b01000},
    {5'b00001, 1'b0, 5'b00000},
    {5'b01001, 1'b0, 5'b00001},
    {5'b01001, 1'b0, 5'b00001},
    {5'b01000, 1'b0, 5'b00000},
    {5'b01000, 1'b0, 5'b01000},
    {5'b00000, 1'b0, 5'b00000}
  };

  localparam logic [10:0] BURST_A_TBL [11] = '{
    {5'b00000, 1'b1, 5'b00000},
    {5'b00000, 1'b1, 5'b00000},
    {5'b00000, 1'b1, 5'b00000},
    {5'b00011, 1'b0, 5'b00001},
    {5'b00011, 1'b1, 5'b00001},
    {5'b00011, 1'b1, 5'b00001},
    {5'b00011, 1'b1, 5'b00001},
    {5'b00011, 1'b1, (LIMIT ? 5'b00000 : 5'b00001)},
    {5'b00011, 1'b0, (LIMIT ? 5'b00010 : 5'b00001)},
    {5'b00001, 1'b0, (LIMIT ? 5'b00000 : 5'b00001)},
    {5'b00000, 1'b0, 5'b00000}
  };

  localparam logic [10:0] BURST_B_TBL [11] = '{
    {5'b00001, 1'b0, 5'b00001},
    {5'b00001, 1'b1, 5'b00001},
    {5'b00001, 1'b1, 5'b00001},
    {5'b00001, 1'b1, 5'b00001},
    {5'b00001, 1'b1, 5'b00001},
    {5'b00001, 1'b1, 5'b00001},
    {5'b00001, 1'b1, 5'b00001},
    {5'b00011, 1'b1, 5'b00001},
    {5'b00011, 1'b1, (LIMIT ? 5'b00000 : 5'b00001)},
    {5'b00011, 1'b0, (LIMIT ? 5'b00010 : 5'b00001)},
    {5'b00000, 1'b0, 5'b00000}
  };

  logic           wb_clk_i = 1'b0;
  logic           wb_rst_i;
  logic [NCH-1:0] wbs_cyc_i;
  logic           wb_ack_i;
  logic [NCH-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [4:0]  exp_q [$];

  wb_rr_arbiter #(
    .NCH       (NCH),
    .IDW       (IDW),
    .MAX_BEATS (4)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wb_ack_i  (wb_ack_i),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_vld   (gnt_vld)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [2:0] oh2id(input logic [4:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  task automatic do_reset();
    wb_rst_i  = 1'b0;
    wbs_cyc_i = '0;
    wb_ack_i  = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    wb_rst_i  = 1'b0;
    wb_ack_i  = 1'b0;
    wbs_cyc_i = 5'b11111;
    exp_q.push_back(5'b00000);
    @(posedge wb_clk_i);
    #1;
    e = exp_q.pop_front();
    total++;
    if (gnt !== e || gnt_vld !== 1'b0 || gnt_id !== 3'd0)
      $display("FAIL reset_hold: gnt=%b vld=%b id=%0d, expected gnt=%b vld=0 id=0", gnt, gnt_vld, gnt_id, e);
    else passed++;
    wb_rst_i = 1'b1;
    exp_q.push_back(5'b00001);
    @(posedge wb_clk_i);
    #1;
    e = exp_q.pop_front();
    total++;
    if (gnt !== e || gnt_vld !== 1'b1 || gnt_id !== 3'd0)
      $display("FAIL reset_first_grant: gnt=%b vld=%b id=%0d, expected gnt=%b vld=1 id=0", gnt, gnt_vld, gnt_id, e);
    else passed++;
  endtask

  task automatic test_rotation();
    logic [4:0] oh, e;
    int         m;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      m  = k % 5;
      oh = 5'b00001 << m;
      for (int r = 0; r < 5; r++) begin
        wbs_cyc_i = (r == 4) ? (5'b11111 & ~oh) : 5'b11111;
        exp_q.push_back((r == 4) ? 5'b00000 : oh);
        @(posedge wb_clk_i);
        #1;
        e = exp_q.pop_front();
        total++;
        if (gnt !== e || gnt_vld !== (|e) || ((|e) && gnt_id !== oh2id(e)))
          $display("FAIL rotation[%0d.%0d]: gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                   k, r, gnt, gnt_vld, gnt_id, e, |e, oh2id(e));
        else passed++;
      end
    end
  endtask

  task automatic test_priority();
    logic [10:0] row;
    logic [4:0]  e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      row = PRIO_TBL[i];
      wbs_cyc_i = row[10:6];
      wb_ack_i  = row[5];
      exp_q.push_back(row[4:0]);
      @(posedge wb_clk_i);
      #1;
      e = exp_q.pop_front();
      total++;
      if (gnt !== e || gnt_vld !== (|e) || ((|e) && gnt_id !== oh2id(e)))
        $display("FAIL priority[%0d]: gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                 i, gnt, gnt_vld, gnt_id, e, |e, oh2id(e));
      else passed++;
    end
  endtask

  task automatic test_rerequest();
    logic [10:0] row;
    logic [4:0]  e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      row = REREQ_TBL[i];
      wbs_cyc_i = row[10:6];
      wb_ack_i  = row[5];
      exp_q.push_back(row[4:0]);
      @(posedge wb_clk_i);
      #1;
      e = exp_q.pop_front();
      total++;
      if (gnt !== e || gnt_vld !== (|e) || ((|e) && gnt_id !== oh2id(e)))
        $display("FAIL rerequest[%0d]: gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                 i, gnt, gnt_vld, gnt_id, e, |e, oh2id(e));
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] e;
    do_reset();
    wbs_cyc_i = 5'b00100;
    exp_q.push_back(5'b00100);
    @(posedge wb_clk_i);
    #1;
    e = exp_q.pop_front();
    total++;
    if (gnt !== e || gnt_vld !== 1'b1 || gnt_id !== 3'd2)
      $display("FAIL async_pre: gnt=%b vld=%b id=%0d, expected gnt=%b vld=1 id=2", gnt, gnt_vld, gnt_id, e);
    else passed++;
    #1;
    wb_rst_i = 1'b0;
    exp_q.push_back(5'b00000);
    #1;
    e = exp_q.pop_front();
    total++;
    if (gnt !== e || gnt_vld !== 1'b0)
      $display("FAIL async_drop: gnt=%b vld=%b, expected gnt=%b vld=0", gnt, gnt_vld, e);
    else passed++;
    wbs_cyc_i = 5'b11111;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b1;
    exp_q.push_back(5'b00001);
    @(posedge wb_clk_i);
    #1;
    e = exp_q.pop_front();
    total++;
    if (gnt !== e || gnt_vld !== 1'b1 || gnt_id !== 3'd0)
      $display("FAIL async_restart: gnt=%b vld=%b id=%0d, expected gnt=%b vld=1 id=0", gnt, gnt_vld, gnt_id, e);
    else passed++;
    wbs_cyc_i = '0;
    exp_q.push_back(5'b00000);
    @(posedge wb_clk_i);
    #1;
    e = exp_q.pop_front();
    total++;
    if (gnt !== e || gnt_vld !== 1'b0)
      $display("FAIL async_release: gnt=%b vld=%b, expected gnt=%b vld=0", gnt, gnt_vld, e);
    else passed++;
  endtask

  task automatic test_burst_limit();
    logic [10:0] row;
    logic [4:0]  e;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      row = BURST_A_TBL[i];
      wbs_cyc_i = row[10:6];
      wb_ack_i  = row[5];
      exp_q.push_back(row[4:0]);
      @(posedge wb_clk_i);
      #1;
      e = exp_q.pop_front();
      total++;
      if (gnt !== e || gnt_vld !== (|e) || ((|e) && gnt_id !== oh2id(e)))
        $display("FAIL burst_contend[%0d]: gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                 i, gnt, gnt_vld, gnt_id, e, |e, oh2id(e));
      else passed++;
    end
  endtask

  task automatic test_burst_wrap();
    logic [10:0] row;
    logic [4:0]  e;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      row = BURST_B_TBL[i];
      wbs_cyc_i = row[10:6];
      wb_ack_i  = row[5];
      exp_q.push_back(row[4:0]);
      @(posedge wb_clk_i);
      #1;
      e = exp_q.pop_front();
      total++;
      if (gnt !== e || gnt_vld !== (|e) || ((|e) && gnt_id !== oh2id(e)))
        $display("FAIL burst_wrap[%0d]: gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                 i, gnt, gnt_vld, gnt_id, e, |e, oh2id(e));
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rotation();
    test_priority();
    test_rerequest();
    test_async_reset();
    test_burst_limit();
    test_burst_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Parametrised round-robin grant arbiter for the ss_adma Wishbone master ports; successor to the fixed 5-way gnt block.
- Accepts NCH cycle requests (one per DMA/SG master), grants exactly one owner at a time and holds the grant for the whole bus cycle.
- Exports a one-hot grant and an encoded owner ID for the shared-bus mux.
- Rotates priority for fairness, with an optional beat-count limit per grant.

Parameters:
- NCH, 5, number of requesting masters (2..16).
- IDW, 3, width of encoded owner ID; must satisfy 2**IDW >= NCH.
- MAX_BEATS, 16, acks allowed per grant before forced release. Used only with GNT_BURST_LIMIT_EN. Range 1..255.

Ports:
- wb_clk_i  input  1  system clock; all logic on its rising edge.
- wb_rst_i  input  1  asynchronous, active-low reset.
- wbs_cyc_i  input  NCH  per-master CYC request; bit i belongs to master i.
- wb_ack_i  input  1  ACK from the shared slave side; counts beats of the current owner.
- gnt  output  NCH  one-hot grant; all zero when the bus is idle.
- gnt_id  output  IDW  index of the current owner; valid only while gnt_vld=1.
- gnt_vld  output  1  high when any grant bit is set; equals the OR of gnt.

Behaviour:
- Reset (wb_rst_i=0, asynchronous): gnt=0, gnt_id=0, gnt_vld=0, state=IDLE, last=NCH-1 (so master 0 wins first), beat counter=0.
- All outputs are registered. There is no combinational path from wbs_cyc_i to gnt.
- State IDLE:
  - gnt=0.
  - If any wbs_cyc_i bit is set at a rising edge, pick the winner: scan from last+1 upward, wrapping modulo NCH, and take the first set bit.
  - On that same edge: load gnt (one-hot), gnt_id and gnt_vld=1; set last=winner; go to BUSY.
  - Request-to-grant latency is 1 cycle.
- State BUSY:
  - Grant is held while wbs_cyc_i[gnt_id]=1. Requests from other masters are ignored.
  - If wbs_cyc_i[gnt_id]=0 at an edge: gnt, gnt_vld cleared on that edge, beat counter cleared, go to IDLE.
  - There is always at least one idle cycle between successive grants (bus turnaround). No back-to-back handoff.
- Fairness:
  - A master that just released the bus has the lowest priority in the next arbitration.
  - With all NCH requesting continuously, grants rotate 0,1,...,NCH-1,0,...
- Simultaneous events:
  - Owner drops CYC in the same cycle other masters raise CYC: release takes priority. The new grant is issued at the following edge from IDLE.
  - Owner re-raises CYC in the idle cycle: it competes normally. It wins only if no master between last+1 and itself is requesting.
- Non-requesting bits: changes on wbs_cyc_i bits other than the owner's have no effect in BUSY.
- wb_ack_i is ignored when gnt_vld=0, or when the feature below is compiled out.
- Beat counter: 8 bits, saturating. Increments on each edge with gnt_vld=1 and wb_ack_i=1.
- Reset mid-operation: outputs drop asynchronously. After reset deassertion, arbitration restarts from master 0.

Optional Feature:
- Macro: GNT_BURST_LIMIT_EN.
- Defined:
  - In BUSY, when the beat counter reaches MAX_BEATS on an ack edge and any other wbs_cyc_i bit is set, the grant is released at that edge and the block goes to IDLE. The owner's CYC is still high.
  - The owner sees gnt low and must stall until re-granted. It is placed last in rotation.
  - If no other master is requesting, the grant is kept and the counter wraps to 0.
- Not defined: the counter and wb_ack_i logic are absent. The grant is held strictly until CYC drops.

Test Plan:
- Reset with wbs_cyc_i=5'b11111 held -> gnt=0 during reset. First edge after release: gnt=5'b00001, gnt_id=0, gnt_vld=1.
- All 5 masters request continuously; each drops CYC 4 cycles after its grant -> grant order 0,1,2,3,4,0, with exactly one gnt=0 cycle between grants.
- Master 2 owns; master 1 and master 4 raise CYC; master 2 drops -> one idle cycle, then gnt=5'b10000 (master 4 precedes 1 after 2), then master 1.
- Owner 3 drops CYC while master 3 re-requests alongside master 0 -> grant goes to 0, not 3.
- Assert wb_rst_i=0 mid-grant (gnt=5'b00100) -> gnt=0 and gnt_vld=0 immediately, without waiting for a clock edge. After release, master 0 is served first.
- With GNT_BURST_LIMIT_EN, MAX_BEATS=4: master 0 streams acks while master 1 waits -> gnt drops on the 4th ack, master 1 is granted after one idle cycle. With master 1 idle, master 0 keeps the grant past 4 acks.
